// File: rtl/sw_pair_sequencer.sv
// Complementary non-overlapping switch-pair PWM sequencer: sw1 on, dead, sw2 on, dead.
// Optional sticky fault latch enabled by defining SW_PAIR_SEQ_FAULT_LATCH_EN.
module sw_pair_sequencer #(
    parameter int CNT_WIDTH  = 16,
    parameter int DEAD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  period,
    input  logic [CNT_WIDTH-1:0]  duty,
    input  logic [DEAD_WIDTH-1:0] dead,
    input  logic                  fault,
    input  logic                  fault_clr,
    output logic                  sw1,
    output logic                  sw2,
    output logic                  cycle_start,
    output logic                  running,
    output logic                  cfg_err,
    output logic                  fault_flag
);
    localparam int W = ((CNT_WIDTH > DEAD_WIDTH) ? CNT_WIDTH : DEAD_WIDTH) + 2;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt, p_q, dc_q;
    logic [DEAD_WIDTH-1:0] t_q;
    logic                  blocked, flt_q;
    logic                  valid_in, take;
    logic [W-1:0]          room;
    logic [CNT_WIDTH-1:0]  dc_in;
    logic [1:0]            dec_new, dec_run;

    // Segment decode at widened precision; {sw1, sw2} for count k.
    function automatic logic [1:0] dec(input logic [CNT_WIDTH-1:0] k, input logic [CNT_WIDTH-1:0] p,
                                       input logic [CNT_WIDTH-1:0] dc, input logic [DEAD_WIDTH-1:0] t);
        logic [W-1:0] kk, pp, dd, tt;
        kk = W'(k);
        pp = W'(p);
        dd = W'(dc);
        tt = W'(t);
        return {kk < dd, (kk >= dd + tt) && (kk < pp - tt)};
    endfunction

    always_comb begin
        room     = W'(period) - (W'(dead) << 1);
        valid_in = (period != '0) && (W'(period) >= (W'(dead) << 1));
        dc_in    = (W'(duty) < room) ? duty : room[CNT_WIDTH-1:0];
        dec_new  = dec('0, period, dc_in, dead);
        dec_run  = dec(cnt + CNT_WIDTH'(1), p_q, dc_q, t_q);
        take     = (state != RUN) || (cnt == p_q - CNT_WIDTH'(1));
    end

`ifdef SW_PAIR_SEQ_FAULT_LATCH_EN
    // Sticky: the clearing edge itself still holds IDLE, restart follows.
    assign blocked = fault | flt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         flt_q <= 1'b0;
        else if (fault)     flt_q <= 1'b1;
        else if (fault_clr) flt_q <= 1'b0;
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign blocked = fault;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flt_q <= 1'b0;
        else        flt_q <= fault;
    end
`endif

    assign fault_flag = flt_q;
    assign running    = (state == RUN);
    assign cfg_err    = (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            p_q         <= '0;
            dc_q        <= '0;
            t_q         <= '0;
            sw1         <= 1'b0;
            sw2         <= 1'b0;
            cycle_start <= 1'b0;
        end else if (!en || blocked) begin
            state       <= IDLE;
            cnt         <= '0;
            sw1         <= 1'b0;
            sw2         <= 1'b0;
            cycle_start <= 1'b0;
        end else if (take) begin
            // Entry, ERR retry or wrap: relatch config and start a fresh cycle.
            p_q  <= period;
            dc_q <= dc_in;
            t_q  <= dead;
            cnt  <= '0;
            if (valid_in) begin
                state       <= RUN;
                cycle_start <= 1'b1;
                sw1         <= dec_new[1];
                sw2         <= dec_new[0];
            end else begin
                state       <= ERR;
                cycle_start <= 1'b0;
                sw1         <= 1'b0;
                sw2         <= 1'b0;
            end
        end else begin
            cnt         <= cnt + CNT_WIDTH'(1);
            cycle_start <= 1'b0;
            sw1         <= dec_run[1];
            sw2         <= dec_run[0];
        end
    end
endmodule

// File: tb/tb_sw_pair_sequencer.sv
// Self-checking bench for sw_pair_sequencer: directed scenarios then random stimulus vs a phase model.
module tb_sw_pair_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] period = 16'd10;
    logic [15:0] duty = 16'd4;
    logic [7:0]  dead = 8'd1;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic        sw1, sw2, cycle_start, running, cfg_err, fault_flag;

    int n_chk = 0;
    int n_err = 0;

    // Model: mode 0=idle 1=run 2=err
    int m_mode, m_cnt, m_p, m_dc, m_t;
    bit m_lat, m_flag, e_sw1, e_sw2, e_cs;

    sw_pair_sequencer #(.CNT_WIDTH(16), .DEAD_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .period(period), .duty(duty), .dead(dead),
        .fault(fault), .fault_clr(fault_clr), .sw1(sw1), .sw2(sw2), .cycle_start(cycle_start),
        .running(running), .cfg_err(cfg_err), .fault_flag(fault_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_p = 0; m_dc = 0; m_t = 0;
        m_lat = 0; m_flag = 0; e_sw1 = 0; e_sw2 = 0; e_cs = 0;
    endtask

    // Which segment of the cycle position k falls in.
    task automatic seg_outputs(input int k);
        e_sw1 = (k < m_dc);
        e_sw2 = (k >= m_dc + m_t) && (k < m_p - m_t);
    endtask

    task automatic model_step();
        bit blk;
`ifdef SW_PAIR_SEQ_FAULT_LATCH_EN
        blk = fault || m_lat;
        if (fault) m_lat = 1;
        else if (fault_clr) m_lat = 0;
        m_flag = m_lat;
`else
        blk = fault;
        m_flag = fault;
`endif
        if (!en || blk) begin
            m_mode = 0; m_cnt = 0; e_sw1 = 0; e_sw2 = 0; e_cs = 0;
        end else if (m_mode != 1 || m_cnt == m_p - 1) begin
            m_p = int'(period); m_t = int'(dead); m_cnt = 0;
            if (m_p == 0 || m_p < 2 * m_t) begin
                m_mode = 2; e_sw1 = 0; e_sw2 = 0; e_cs = 0;
            end else begin
                m_mode = 1; e_cs = 1;
                m_dc = (int'(duty) < m_p - 2 * m_t) ? int'(duty) : m_p - 2 * m_t;
                seg_outputs(0);
            end
        end else begin
            m_cnt++; e_cs = 0;
            seg_outputs(m_cnt);
        end
    endtask

    task automatic check_all();
        chk("sw1", sw1, e_sw1);
        chk("sw2", sw2, e_sw2);
        chk("cycle_start", cycle_start, e_cs);
        chk("running", running, m_mode == 1);
        chk("cfg_err", cfg_err, m_mode == 2);
        chk("fault_flag", fault_flag, m_flag);
        chk("no_overlap", sw1 & sw2, 0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1 check_all();
            @(negedge clk);
        end
    endtask

    task automatic run_until_cnt(input int target);
        for (int i = 0; i < 40 && !(m_mode == 1 && m_cnt == target); i++) tick(1);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_sw1", sw1, 0);
        chk("rst_sw2", sw2, 0);
        chk("rst_cs", cycle_start, 0);
        chk("rst_running", running, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_fault_flag", fault_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Nominal P=10 D=4 T=1; first edge with en must raise sw1.
        en = 1'b1;
        tick(1);
        chk("first_sw1", sw1, 1);
        tick(24);

        // Mid-cycle duty change takes effect at the next wrap.
        run_until_cnt(3);
        duty = 16'd2;
        tick(25);

        // Clamp: sw1 widened to P-2T, sw2 disappears.
        duty = 16'd20;
        tick(25);

        // Fault pulse at cnt 2, then optional clear.
        duty = 16'd4;
        tick(12);
        run_until_cnt(2);
        fault = 1'b1;
        tick(1);
        chk("fault_sw1_off", sw1, 0);
        fault = 1'b0;
        tick(5);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        tick(12);

        // Invalid config: P=3 T=2 goes to ERR, fixing P recovers.
        en = 1'b0;
        tick(1);
        period = 16'd3; dead = 8'd2;
        en = 1'b1;
        tick(3);
        chk("err_flag", cfg_err, 1);
        period = 16'd10;
        tick(1);
        chk("err_recover", running, 1);
        dead = 8'd1;
        tick(12);

        // Async reset inside the sw2 interval clears outputs without a clock.
        run_until_cnt(6);
        chk("pre_rst_sw2", sw2, 1);
        rst_n = 1'b0;
        #1;
        chk("async_sw2", sw2, 0);
        chk("async_sw1", sw1, 0);
        chk("async_running", running, 0);
        model_reset();
        #2 rst_n = 1'b1;
        tick(15);

        // Random en/fault/config with T=0 and degenerate segments included.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 16) != 0;
            fault = ($urandom % 40) == 0;
            fault_clr = ($urandom % 6) == 0;
            if (($urandom % 8) == 0) begin
                period = 16'($urandom_range(0, 20));
                duty = 16'($urandom_range(0, 25));
                dead = 8'($urandom_range(0, 8));
            end
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sw_pair_sequencer.md
Name: sw_pair_sequencer

Overview:
- Clocked controller that drives the two switch-control inputs (sw1, sw2) of a switched-circuit model as a complementary, non-overlapping pair.
- Generates a fixed-period PWM cycle: sw1 on-interval, dead time, sw2 on-interval, dead time.
- Re-latches its configuration only at cycle boundaries.
- Sits beside the analog model wrapper in the emulation top; the shared clock also advances the model.

Parameters:
CNT_WIDTH, 16, width of period/duty counters and config inputs
DEAD_WIDTH, 8, width of dead-time config input

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run request; sampled each edge
period  input  CNT_WIDTH  cycle length P in clocks
duty  input  CNT_WIDTH  requested sw1 on-time D in clocks
dead  input  DEAD_WIDTH  dead time T in clocks, both switches off
fault  input  1  synchronous force-off request
fault_clr  input  1  clears latched fault (see Optional Feature)
sw1  output  1  switch 1 drive, registered
sw2  output  1  switch 2 drive, registered
cycle_start  output  1  one-clock pulse on first clock of every cycle
running  output  1  high while in RUN state
cfg_err  output  1  latched config invalid
fault_flag  output  1  fault status

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE, cnt 0, latched config 0.
- States:
  - IDLE: en=0 or fault active.
  - RUN: cycling.
  - ERR: en=1 but latched config invalid.
- Latching: config (P, D, T) is latched on the edge entering RUN/ERR and on every cycle wrap; mid-cycle input changes are ignored.
- Validity: invalid if P==0 or P < 2*T. Compare at CNT_WIDTH+1 bits with no overflow.
- Clamp: Dc = min(D, P-2T).
- Counter: cnt runs 0..P-1, +1 per edge; wraps P-1 -> 0.
- Output decode from cnt, registered. Outputs on the edge that loads cnt=k reflect k:
  - sw1 = (k < Dc)
  - sw2 = (k >= Dc+T) && (k < P-T)
- IDLE -> RUN:
  - Edge sampling en=1, fault=0, valid config.
  - Same edge: cnt=0, cycle_start=1, sw1=(Dc>0). Latency is 1 clock from en sample to sw1 high.
- IDLE/RUN -> ERR:
  - Triggered by invalid latched config.
  - sw1=sw2=0, cfg_err=1.
  - ERR re-samples config every edge; if valid, goes to RUN with cnt=0 and cfg_err=0.
- RUN -> IDLE:
  - Edge sampling en=0 or fault active.
  - Same edge: sw1=sw2=0, cnt=0, cycle_start=0. No completion of the current cycle.
- Wrap: edge where cnt==P-1 loads cnt=0, pulses cycle_start, and relatches config. sw outputs use the new config on that same edge.
- Zero-length segments:
  - Dc=0: sw1 never high.
  - Dc=P-2T: sw2 never high.
  - T=0: switches hand over with no gap. Still never simultaneously high.
- Invariant: sw1 && sw2 never 1 on any clock, including reset, fault, en toggle, and config change.
- Simultaneous events:
  - fault outranks en.
  - rst_n outranks all.
  - Reset mid-cycle forces outputs to 0 asynchronously.
- running = (state==RUN).

Optional Feature:
- Macro: SW_PAIR_SEQ_FAULT_LATCH_EN.
- Defined:
  - fault=1 sets a sticky fault latch, and fault_flag=1 from the next edge.
  - While latched, the block is held in IDLE even after fault drops.
  - Cleared by fault_clr=1 on an edge where fault=0; restart is then allowed next edge if en=1.
  - fault_clr while fault=1 is ignored.
- Undefined:
  - fault_flag = registered fault; the block is forced to IDLE only while fault=1 (self-clearing).
  - fault_clr is ignored.

Test Plan:
- Nominal: P=10, D=4, T=1, en=1 -> per cycle, sw1=1 at cnt 0-3, both 0 at cnt 4, sw2=1 at cnt 5-8, both 0 at cnt 9. cycle_start every 10 clocks; first sw1 high 1 clock after en sampled.
- Clamp: P=10, D=20, T=1 -> sw1=1 at cnt 0-7, sw2 never high, both 0 at cnt 8-9.
- Config change mid-cycle: D 4->2 at cnt=3 -> current cycle unchanged; next cycle sw1 at cnt 0-1, sw2 at cnt 3-8.
- Invalid: P=3, T=2 -> ERR, cfg_err=1, sw off. Set P=10 -> RUN next edge, cnt=0, cfg_err=0.
- Fault at cnt=2, one-clock pulse:
  - sw1 0 next edge.
  - Without macro: restart 1 clock after fault drops.
  - With macro: held off until fault_clr, then restart.
- Async reset asserted mid sw2 interval -> sw2 0 immediately without a clock. Shoot-through checker asserts sw1 && sw2 never 1 across the whole run with random en/fault/config.
